next_line_prefetcher: RTL
=========================

NEXT_LINE_PREFETCHER -- requirements
Module: next_line_prefetcher

Interface
REQ-001 Parameter NUM_ENTRIES, default 4: prefetch-buffer lines, fully associative, power of two, 2..16.
REQ-002 Parameter PF_DEGREE, default 2: lines fetched ahead of each demand read, 1..NUM_ENTRIES.
REQ-003 Port clk  in  1  clock; all state on rising edge.
REQ-004 Port rst  in  1  reset, synchronous, active-high.
REQ-005 Port pf_en  in  1  prefetch enable; low blocks new prefetch sequences, buffer hits still served.
REQ-006 Ports ufp_addr in 32, ufp_read in 1, ufp_write in 1, ufp_wdata in 256: cache-side line request, held stable until ufp_resp.
REQ-007 Ports ufp_rdata out 256, ufp_resp out 1: read line data, one-cycle completion pulse.
REQ-008 Ports dfp_addr out 32, dfp_read out 1, dfp_write out 1, dfp_wdata out 256: memory request, single outstanding, held until dfp_resp.
REQ-009 Ports dfp_rdata in 256, dfp_resp in 1: memory read data, one-cycle completion pulse.
REQ-010 Port perf_pf_hits  out 32  count of demand reads served from buffer, wraps modulo 2^32.

Function
REQ-011 Addresses are 32-byte line aligned; dfp_addr[4:0] SHALL always be 0; ufp_addr[4:0] ignored.
REQ-012 FSM states: IDLE, HIT_RESP, DEM_RD, DEM_WR, RESP, PF_ISSUE, PF_WAIT.
REQ-013 IDLE, ufp_read, buffer hit -> HIT_RESP; next cycle ufp_resp=1 with entry data, entry invalidated, perf_pf_hits+1 (latency 1 cycle).
REQ-014 IDLE, ufp_read, miss -> DEM_RD; dfp_read=1, dfp_addr=line address until dfp_resp; -> RESP; ufp_resp=1 with captured dfp_rdata the cycle after dfp_resp.
REQ-015 IDLE, ufp_write -> invalidate matching entry same edge, DEM_WR forwards dfp_write/dfp_wdata until dfp_resp, ufp_resp the following cycle; no prefetch triggered.
REQ-016 ufp_read and ufp_write both high: write wins, read ignored.
REQ-017 After ufp_resp of a demand read with pf_en=1: pf_base=line address, pf_cnt=1, -> PF_ISSUE; else -> IDLE.
REQ-018 PF_ISSUE: candidate=pf_base+32*pf_cnt; if already in buffer, skip (pf_cnt+1, one cycle, no memory access); else dfp_read, -> PF_WAIT.
REQ-019 PF_WAIT on dfp_resp: fill into an invalid entry, else into entry at FIFO pointer; pointer advances on every fill, wraps at NUM_ENTRIES.
REQ-020 Sequence ends (-> IDLE) when pf_cnt exceeds PF_DEGREE or candidate lies in a different 4 KiB page than pf_base.
REQ-021 Demand request seen in PF_ISSUE aborts remaining prefetches; demand handled next cycle as from IDLE.
REQ-022 Demand request seen in PF_WAIT waits for dfp_resp; fill completes first; if demand read address equals in-flight address, ufp_resp=1 with that data the cycle after dfp_resp, entry not retained, no second memory read.
REQ-023 Demand write matching in-flight prefetch address: fill is discarded, write then proceeds.
REQ-024 pf_en deasserted mid-sequence: in-flight prefetch completes and fills, then -> IDLE.
REQ-025 ufp_resp SHALL be asserted exactly once per accepted request; dfp_read and dfp_write never high together.

Reset
REQ-026 On rst: state IDLE, all valid bits 0, FIFO pointer 0, pf_cnt 0, perf_pf_hits 0.
REQ-027 On rst: ufp_resp, dfp_read, dfp_write 0; ufp_rdata, dfp_wdata, dfp_addr 0.
REQ-028 rst mid-transfer abandons it; the dfp_resp of the abandoned transfer, if it arrives after rst, is ignored.

Structure
REQ-029 Package pf_pkg holds the state enum, LINE_BYTES=32, PAGE_BYTES=4096, and entry struct {valid, tag[26:0], data[255:0]}.
REQ-030 Sub-module pf_buffer holds storage, parallel tag lookup, allocate and invalidate; the top level holds the FSM and counters.

Verification
REQ-031 Read 0x1000 miss, memory latency 5 cycles -> ufp_resp at cycle 7; then dfp_read for 0x1020 and 0x1040, both filled.
REQ-032 Next, read 0x1020 -> ufp_resp 1 cycle later, no dfp activity before response, perf_pf_hits=1, prefetch of 0x1040 skipped, 0x1060 fetched.
REQ-033 Read 0x1FE0 -> demand line only; no prefetch of 0x2000 (page crossing).
REQ-034 Read 0x3000, then read 0x3020 issued during PF_WAIT for 0x3020 -> single memory read of 0x3020, ufp_resp the cycle after its dfp_resp.
REQ-035 Write 0x1040 while 0x1040 is buffered -> entry invalidated; subsequent read 0x1040 misses and issues dfp_read.
REQ-036 NUM_ENTRIES=4, PF_DEGREE=4, six sequential misses -> oldest entries replaced in FIFO order; rst mid-PF_WAIT -> all outputs 0 next cycle, buffer empty.

Source files
------------

// File: rtl/pf_pkg.sv
// Shared types and geometry for the next-line prefetcher.
package pf_pkg;

  localparam int LINE_BYTES = 32;
  localparam int PAGE_BYTES = 4096;
  localparam int OFS_W      = $clog2(LINE_BYTES);
  localparam int TAG_W      = 32 - OFS_W;
  // Line-tag bits below this position stay inside one page.
  localparam int PG_SH      = $clog2(PAGE_BYTES) - OFS_W;

  typedef enum logic [2:0] {
    IDLE,
    HIT_RESP,
    DEM_RD,
    DEM_WR,
    RESP,
    PF_ISSUE,
    PF_WAIT
  } pf_state_e;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [255:0]      data;
  } pf_entry_t;

  function automatic logic same_page(input logic [TAG_W-1:0] a, input logic [TAG_W-1:0] b);
    return a[TAG_W-1:PG_SH] == b[TAG_W-1:PG_SH];
  endfunction

endpackage

// File: rtl/pf_buffer.sv
// Fully associative prefetch line buffer: parallel tag match, single-entry
// invalidate, and fill into a free slot or the FIFO victim.
module pf_buffer
  import pf_pkg::*;
#(
  parameter int NUM_ENTRIES = 4,
  localparam int IDX_W = $clog2(NUM_ENTRIES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TAG_W-1:0]  lookup_tag,
  output logic              hit,
  output logic [IDX_W-1:0]  hit_idx,
  output logic [255:0]      hit_data,
  input  logic              inv_en,
  input  logic [IDX_W-1:0]  inv_idx,
  input  logic              fill_en,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic [255:0]      fill_data
);

  pf_entry_t              entries [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] match;
  logic [NUM_ENTRIES-1:0] free;
  logic [IDX_W-1:0]       ptr;
  logic [IDX_W-1:0]       free_idx;
  logic [IDX_W-1:0]       victim;
  logic                   have_free;

  for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_cmp
    assign match[i] = entries[i].valid && (entries[i].tag == lookup_tag);
    assign free[i]  = !entries[i].valid;
  end

  // Downward scan so the lowest matching / free index wins.
  always_comb begin
    hit       = 1'b0;
    hit_idx   = '0;
    have_free = 1'b0;
    free_idx  = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (free[i]) begin
        have_free = 1'b1;
        free_idx  = IDX_W'(i);
      end
    end
    hit_data = entries[hit_idx].data;
    victim   = have_free ? free_idx : ptr;
  end

  // ptr advances on every fill, even into a free slot; wraps as a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) entries[i].valid <= 1'b0;
      ptr <= '0;
    end else begin
      if (inv_en) entries[inv_idx].valid <= 1'b0;
      if (fill_en) begin
        entries[victim] <= '{valid: 1'b1, tag: fill_tag, data: fill_data};
        ptr             <= ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/next_line_prefetcher.sv
// Next-line prefetcher between cache (ufp) and memory (dfp): demand reads
// trigger up to PF_DEGREE sequential line prefetches within the same page.
module next_line_prefetcher
  import pf_pkg::*;
#(
  parameter int NUM_ENTRIES = 4,
  parameter int PF_DEGREE   = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pf_en,
  input  logic [31:0]  ufp_addr,
  input  logic         ufp_read,
  input  logic         ufp_write,
  input  logic [255:0] ufp_wdata,
  output logic [255:0] ufp_rdata,
  output logic         ufp_resp,
  output logic [31:0]  dfp_addr,
  output logic         dfp_read,
  output logic         dfp_write,
  output logic [255:0] dfp_wdata,
  input  logic [255:0] dfp_rdata,
  input  logic         dfp_resp,
  output logic [31:0]  perf_pf_hits
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int CNT_W = $clog2(PF_DEGREE + 2);

  pf_state_e        state, state_n;
  logic [TAG_W-1:0] pf_base, dem_tag, addr_q;
  logic [CNT_W-1:0] pf_cnt;
  logic             dem_rd;
  logic [255:0]     rdata_q, wdata_q;
  logic [31:0]      hits;

  logic [TAG_W-1:0] ufp_tag, cand_tag, lookup_tag;
  logic             hit;
  logic [IDX_W-1:0] hit_idx;
  logic [255:0]     hit_data;
  logic             inv_en, fill_en;
  logic             ld_dem, ld_hit, ld_rdata, pf_start, pf_step, pf_issue;
  logic             demand, wait_match;
  logic             unused_ofs;

  assign ufp_tag    = ufp_addr[31:OFS_W];
  assign unused_ofs = ^ufp_addr[OFS_W-1:0];
  assign cand_tag   = pf_base + TAG_W'(pf_cnt);
  assign lookup_tag = (state == PF_ISSUE) ? cand_tag : ufp_tag;
  assign demand     = ufp_read || ufp_write;
  assign wait_match = (ufp_tag == addr_q);

  pf_buffer #(.NUM_ENTRIES(NUM_ENTRIES)) u_buf (
    .clk        (clk),
    .rst        (rst),
    .lookup_tag (lookup_tag),
    .hit        (hit),
    .hit_idx    (hit_idx),
    .hit_data   (hit_data),
    .inv_en     (inv_en),
    .inv_idx    (hit_idx),
    .fill_en    (fill_en),
    .fill_tag   (addr_q),
    .fill_data  (dfp_rdata)
  );

  assign ufp_resp     = (state == HIT_RESP) || (state == RESP);
  assign ufp_rdata    = rdata_q;
  assign dfp_read     = (state == DEM_RD) || (state == PF_WAIT);
  assign dfp_write    = (state == DEM_WR);
  assign dfp_addr     = {addr_q, {OFS_W{1'b0}}};
  assign dfp_wdata    = wdata_q;
  assign perf_pf_hits = hits;

  always_comb begin
    state_n  = state;
    inv_en   = 1'b0;
    fill_en  = 1'b0;
    ld_dem   = 1'b0;
    ld_hit   = 1'b0;
    ld_rdata = 1'b0;
    pf_start = 1'b0;
    pf_step  = 1'b0;
    pf_issue = 1'b0;
    unique case (state)
      IDLE: begin
        if (ufp_write) begin
          ld_dem  = 1'b1;
          inv_en  = hit;
          state_n = DEM_WR;
        end else if (ufp_read) begin
          ld_dem = 1'b1;
          if (hit) begin
            ld_hit  = 1'b1;
            inv_en  = 1'b1;
            state_n = HIT_RESP;
          end else begin
            state_n = DEM_RD;
          end
        end
      end
      HIT_RESP, RESP: begin
        if (dem_rd && pf_en) begin
          pf_start = 1'b1;
          state_n  = PF_ISSUE;
        end else begin
          state_n = IDLE;
        end
      end
      DEM_RD: begin
        if (dfp_resp) begin
          ld_rdata = 1'b1;
          state_n  = RESP;
        end
      end
      DEM_WR: begin
        if (dfp_resp) state_n = RESP;
      end
      PF_ISSUE: begin
        // A pending demand aborts the sequence; IDLE picks it up next cycle.
        if (demand || !pf_en || (pf_cnt > CNT_W'(PF_DEGREE)) || !same_page(cand_tag, pf_base)) begin
          state_n = IDLE;
        end else if (hit) begin
          pf_step = 1'b1;
        end else begin
          pf_step  = 1'b1;
          pf_issue = 1'b1;
          state_n  = PF_WAIT;
        end
      end
      PF_WAIT: begin
        if (dfp_resp) begin
          if (ufp_write && wait_match) begin
            // Fill would be stale once the write lands; drop it.
            state_n = IDLE;
          end else if (ufp_read && wait_match) begin
            // Hand the in-flight line straight to the demand read.
            ld_dem   = 1'b1;
            ld_rdata = 1'b1;
            state_n  = RESP;
          end else begin
            fill_en = 1'b1;
            state_n = (demand || !pf_en) ? IDLE : PF_ISSUE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pf_base <= '0;
      pf_cnt  <= '0;
      dem_tag <= '0;
      dem_rd  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      hits    <= '0;
    end else begin
      state <= state_n;
      if (ld_dem) begin
        dem_tag <= ufp_tag;
        dem_rd  <= !ufp_write;
        addr_q  <= ufp_tag;
        wdata_q <= ufp_wdata;
      end
      if (ld_hit) begin
        rdata_q <= hit_data;
        hits    <= hits + 32'd1;
      end
      if (ld_rdata) rdata_q <= dfp_rdata;
      if (pf_start) begin
        pf_base <= dem_tag;
        pf_cnt  <= CNT_W'(1);
      end
      if (pf_step)  pf_cnt <= pf_cnt + 1'b1;
      if (pf_issue) addr_q <= cand_tag;
    end
  end

endmodule
